// File: rtl/conv_row_accumulator.sv
// Row-sum accumulator behind the 1-D adder tree: sums KERNEL_SIZE partial sums, biases, shifts,
// saturates and queues pixels in a small output FIFO. Optional round-half-up via QUANT_ROUND_EN.
module conv_row_accumulator #(
    parameter int KERNEL_SIZE  = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int FIFO_DEPTH   = 4,
    localparam int IN_WIDTH    = DATA_WIDTH + WEIGHT_WIDTH + KERNEL_SIZE,
    localparam int ACC_WIDTH   = IN_WIDTH + $clog2(KERNEL_SIZE) + 1,
    localparam int LVL_WIDTH   = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  acc_valid,
    input  logic [IN_WIDTH-1:0]   acc_dataIn,
    input  logic                  acc_clear,
    input  logic [ACC_WIDTH-1:0]  bias,
    input  logic [4:0]            shift,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [LVL_WIDTH-1:0]  fifo_level,
    output logic                  overflow
);

    localparam int CNT_W = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    // Two guard bits: one for bias addition, one for the rounding increment.
    localparam int T_W   = ACC_WIDTH + 2;

    logic [ACC_WIDTH-1:0]  acc_q;
    logic [CNT_W-1:0]      row_cnt_q;
    logic [ACC_WIDTH-1:0]  sum_q;
    logic                  sum_vld_q;
    logic [DATA_WIDTH-1:0] pix_q;
    logic                  pix_vld_q;
    logic                  overflow_q;
    logic [DATA_WIDTH-1:0] last_q;
    logic [PTR_W:0]        wr_ptr_q;
    logic [PTR_W:0]        rd_ptr_q;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic                  last_row;
    logic [ACC_WIDTH-1:0]  row_sum;
    logic signed [T_W-1:0] t_val;
    logic signed [T_W-1:0] r_val;
    logic [DATA_WIDTH-1:0] pix_d;
    logic [PTR_W:0]        level;
    logic                  full;
    logic                  empty;
    logic                  pop;
    logic                  push;
    logic                  drop;

    assign last_row = (row_cnt_q == CNT_W'(KERNEL_SIZE - 1));
    assign row_sum  = acc_q + {{(ACC_WIDTH-IN_WIDTH){1'b0}}, acc_dataIn};

    always_comb begin
        t_val = {{2{sum_q[ACC_WIDTH-1]}}, sum_q} + {{2{bias[ACC_WIDTH-1]}}, bias};
`ifdef QUANT_ROUND_EN
        if (shift != 5'd0) begin
            t_val = t_val + (T_W'(1) << (shift - 5'd1));
        end
`endif
        r_val = t_val >>> shift;
        if (r_val[T_W-1]) begin
            pix_d = '0;
        end else if (|r_val[T_W-2:DATA_WIDTH]) begin
            pix_d = '1;
        end else begin
            pix_d = r_val[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q     <= '0;
            row_cnt_q <= '0;
            sum_q     <= '0;
            sum_vld_q <= 1'b0;
            pix_q     <= '0;
            pix_vld_q <= 1'b0;
        end else if (acc_clear) begin
            acc_q     <= '0;
            row_cnt_q <= '0;
            sum_vld_q <= 1'b0;
            pix_vld_q <= 1'b0;
        end else begin
            if (acc_valid) begin
                if (last_row) begin
                    acc_q     <= '0;
                    row_cnt_q <= '0;
                    sum_q     <= row_sum;
                end else begin
                    acc_q     <= row_sum;
                    row_cnt_q <= row_cnt_q + CNT_W'(1);
                end
            end
            sum_vld_q <= acc_valid && last_row;
            pix_vld_q <= sum_vld_q;
            if (sum_vld_q) begin
                pix_q <= pix_d;
            end
        end
    end

    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == (PTR_W+1)'(FIFO_DEPTH));
    assign empty = (level == '0);
    assign pop   = !empty && out_ready;
    // A full FIFO can still take a pixel if the head leaves on the same edge.
    assign push  = pix_vld_q && (!full || pop);
    assign drop  = pix_vld_q && full && !pop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            last_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[PTR_W-1:0]] <= pix_q;
                wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
            end
            if (pop) begin
                last_q   <= mem_q[rd_ptr_q[PTR_W-1:0]];
                rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
            end
            if (acc_clear) begin
                overflow_q <= 1'b0;
            end else if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign out_valid  = !empty;
    assign out_data   = empty ? last_q : mem_q[rd_ptr_q[PTR_W-1:0]];
    assign fifo_level = level;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_conv_row_accumulator.sv
// Scoreboard bench for conv_row_accumulator: directed cases plus randomized frames against a
// behavioural pixel model; a forked monitor checks every FIFO pop against the expected queue.
module tb_conv_row_accumulator;

    localparam int IN_W  = 19;
    localparam int ACC_W = 22;

    logic              clk = 1'b0;
    logic              rstn;
    logic              acc_valid;
    logic [IN_W-1:0]   acc_dataIn;
    logic              acc_clear;
    logic [ACC_W-1:0]  bias;
    logic [4:0]        shift;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic [2:0]        fifo_level;
    logic              overflow;

    conv_row_accumulator dut (
        .clk        (clk),
        .rstn       (rstn),
        .acc_valid  (acc_valid),
        .acc_dataIn (acc_dataIn),
        .acc_clear  (acc_clear),
        .bias       (bias),
        .shift      (shift),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int exp_q[$];
    bit rnd_rdy = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference pixel: plain integer arithmetic on the whole frame sum.
    function automatic int model(input longint s, input longint b, input int sh);
        longint t;
        t = s + b;
`ifdef QUANT_ROUND_EN
        if (sh > 0) t = t + (longint'(1) <<< (sh - 1));
`endif
        t = t >>> sh;
        if (t < 0) return 0;
        if (t > 255) return 255;
        return int'(t);
    endfunction

    task automatic monitor();
        int e;
        forever begin
            @(negedge clk);
            if (rstn && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pixel", out_data, -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel", out_data, e);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_row(input int v);
        acc_valid  = 1'b1;
        acc_dataIn = IN_W'(v);
        tick();
        acc_valid  = 1'b0;
    endtask

    task automatic send_pix(input int a, input int b, input int c);
        send_row(a);
        send_row(b);
        send_row(c);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) chk("drain_timeout", exp_q.size(), 0);
        idle(2);
    endtask

    task automatic pulse_clear();
        acc_clear = 1'b1;
        tick();
        acc_clear = 1'b0;
    endtask

    initial begin
        longint s, b;
        int sh, r;
        rstn = 1'b0; acc_valid = 1'b0; acc_dataIn = '0; acc_clear = 1'b0;
        bias = '0; shift = '0; out_ready = 1'b1;
        fork monitor(); join_none
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_overflow", overflow, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        idle(2);

        // Basic with latency
        shift = 5'd2;
        send_row(100); send_row(200);
        exp_q.push_back(150);
        send_row(300);
        chk("lat_e0", out_valid, 0);
        tick();
        chk("lat_e1", out_valid, 0);
        tick();
        chk("lat_e2", out_valid, 1);
        drain();

        // Negative clamp
        shift = 5'd0; bias = ACC_W'(-700);
        exp_q.push_back(0);
        send_pix(100, 200, 300);
        drain();
        bias = '0;

        // Positive saturation
        exp_q.push_back(255);
        send_pix(40000, 40000, 40000);
        drain();

        // Rounding
        shift = 5'd2;
`ifdef QUANT_ROUND_EN
        exp_q.push_back(2);
`else
        exp_q.push_back(1);
`endif
        send_pix(1, 2, 3);
        drain();
        shift = 5'd0;

        // Overflow
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) exp_q.push_back(k);
            send_pix(k, 0, 0);
        end
        idle(4);
        chk("ovf_level", fifo_level, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head_stable", out_data, 1);
        out_ready = 1'b1;
        drain();
        chk("ovf_drained_level", fifo_level, 0);
        chk("ovf_sticky", overflow, 1);
        pulse_clear();
        chk("ovf_cleared", overflow, 0);

        // Mid-frame reset
        send_row(5); send_row(6);
        rstn = 1'b0;
        tick();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        rstn = 1'b1;
        idle(4);
        chk("mid_rst_no_out", out_valid, 0);
        exp_q.push_back(60);
        send_pix(10, 20, 30);
        drain();

        // Mid-frame clear, with a clear colliding with a row
        send_row(5); send_row(6);
        acc_clear = 1'b1; acc_valid = 1'b1; acc_dataIn = IN_W'(7);
        tick();
        acc_clear = 1'b0; acc_valid = 1'b0;
        idle(4);
        chk("mid_clr_no_out", out_valid, 0);
        exp_q.push_back(60);
        send_pix(10, 20, 30);
        drain();

        // Randomized frames
        rnd_rdy = 1;
        for (int p = 0; p < 40; p++) begin
            b  = longint'($urandom_range(0, 2 * (1 << 20))) - (1 << 20);
            sh = int'($urandom_range(0, 12));
            bias  = ACC_W'(b);
            shift = 5'(sh);
            s = 0;
            for (int rw = 0; rw < 3; rw++) begin
                r = int'($urandom_range(0, (1 << IN_W) - 1));
                if ($urandom_range(0, 3) == 0) r = int'($urandom_range(0, 300));
                s = s + r;
                if (rw == 2) exp_q.push_back(model(s, b, sh));
                send_row(r);
                idle(int'($urandom_range(0, 2)));
            end
            idle(2);
        end
        rnd_rdy = 0;
        out_ready = 1'b1;
        drain();
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_overflow", overflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
